// File: rtl/config_pkg.sv
// Core configuration record and shared frontend predictor types.
// Helpers derive gshare table geometry from the config.
package config_pkg;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned FETCH_WIDTH;
    int unsigned frontedn_hash_LEN;
    int unsigned frontend_predict_LEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{
    VLEN:                 32,
    FETCH_WIDTH:          4,
    frontedn_hash_LEN:    4,
    frontend_predict_LEN: 2
  };

  function automatic int unsigned bpu_nent(cfg_t c);
    return 32'd1 << c.frontedn_hash_LEN;
  endfunction

  // Weakly not-taken: one below the counter midpoint.
  function automatic int unsigned bpu_cinit(cfg_t c);
    return (32'd1 << (c.frontend_predict_LEN - 1)) - 32'd1;
  endfunction

  typedef struct packed {
    logic [EmptyCfg.VLEN-1:0]              pc;
    logic [EmptyCfg.frontedn_hash_LEN-1:0] ghr;
    logic                                  taken;
    logic                                  mispredict;
  } bpu_upd_t;

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: saturating counters, FETCH_WIDTH
// combinational read ports, one write port.
module bpu_pht
  import config_pkg::*;
#(
  parameter cfg_t Cfg = EmptyCfg
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [Cfg.FETCH_WIDTH-1:0][Cfg.frontedn_hash_LEN-1:0]
               rd_idx_i,
  output logic [Cfg.FETCH_WIDTH-1:0][Cfg.frontend_predict_LEN-1:0]
               rd_cnt_o,
  input  logic wr_en_i,
  input  logic [Cfg.frontedn_hash_LEN-1:0] wr_idx_i,
  input  logic wr_taken_i
);

  localparam int FW   = int'(Cfg.FETCH_WIDTH);
  localparam int CW   = int'(Cfg.frontend_predict_LEN);
  localparam int NENT = int'(bpu_nent(Cfg));
  localparam logic [CW-1:0] CINIT = CW'(bpu_cinit(Cfg));
  localparam logic [CW-1:0] CMAX  = '1;

  logic [CW-1:0] cnt_q [NENT];
  logic [CW-1:0] wr_cur;

  assign wr_cur = cnt_q[wr_idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NENT; i++) cnt_q[i] <= CINIT;
    end else if (wr_en_i) begin
      if (wr_taken_i && wr_cur != CMAX)
        cnt_q[wr_idx_i] <= wr_cur + 1'b1;
      else if (!wr_taken_i && wr_cur != '0)
        cnt_q[wr_idx_i] <= wr_cur - 1'b1;
    end
  end

  always_comb begin
    rd_cnt_o = '0;
    for (int i = 0; i < FW; i++) rd_cnt_o[i] = cnt_q[rd_idx_i[i]];
  end

endmodule

// File: rtl/bpu_gshare.sv
// Gshare direction predictor: speculative GHR, index hash and
// one-cycle registered per-slot response.
module bpu_gshare
  import config_pkg::*;
#(
  parameter cfg_t Cfg = EmptyCfg
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic [Cfg.VLEN-1:0] req_pc_i,
  output logic resp_valid_o,
  output logic [Cfg.FETCH_WIDTH-1:0] resp_taken_o,
  output logic [Cfg.frontedn_hash_LEN-1:0] resp_ghr_o,
  input  logic spec_valid_i,
  input  logic spec_taken_i,
  input  logic upd_valid_i,
  input  logic [Cfg.VLEN-1:0] upd_pc_i,
  input  logic [Cfg.frontedn_hash_LEN-1:0] upd_ghr_i,
  input  logic upd_taken_i,
  input  logic upd_mispredict_i,
  output logic [Cfg.frontedn_hash_LEN-1:0] ghr_o
);

  localparam int VLEN = int'(Cfg.VLEN);
  localparam int FW   = int'(Cfg.FETCH_WIDTH);
  localparam int HL   = int'(Cfg.frontedn_hash_LEN);
  localparam int CW   = int'(Cfg.frontend_predict_LEN);

  if (HL < 1 || HL > VLEN - 2 || CW < 2 || FW < 1) begin : g_cfg_err
    $error("bpu_gshare: illegal configuration");
  end

  logic [HL-1:0] ghr_q;
  logic [HL-1:0] ghr_d;
  logic [FW-1:0][VLEN-1:0] slot_pc;
  logic [FW-1:0][HL-1:0] rd_idx;
  logic [FW-1:0][CW-1:0] rd_cnt;
  logic [FW-1:0] taken;
  logic [HL-1:0] wr_idx;

  // Slot PCs wrap naturally at 2**VLEN.
  always_comb begin
    slot_pc = '0;
    rd_idx  = '0;
    taken   = '0;
    for (int i = 0; i < FW; i++) begin
      slot_pc[i] = req_pc_i + VLEN'(4 * i);
      rd_idx[i]  = slot_pc[i][HL+1:2] ^ ghr_q;
      taken[i]   = rd_cnt[i][CW-1];
    end
  end

  assign wr_idx = upd_pc_i[HL+1:2] ^ upd_ghr_i;

  bpu_pht #(.Cfg(Cfg)) u_pht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (rd_idx),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (upd_valid_i),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (upd_taken_i)
  );

  // Shift form is valid for HL == 1 as well.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i && upd_mispredict_i)
      ghr_d = (upd_ghr_i << 1) | HL'(upd_taken_i);
    else if (spec_valid_i)
      ghr_d = (ghr_q << 1) | HL'(spec_taken_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q        <= '0;
      resp_valid_o <= 1'b0;
      resp_taken_o <= '0;
      resp_ghr_o   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      resp_valid_o <= req_valid_i;
      if (req_valid_i) begin
        resp_taken_o <= taken;
        resp_ghr_o   <= ghr_q;
      end
    end
  end

  assign ghr_o = ghr_q;

  logic unused_pc;
  assign unused_pc = ^{slot_pc, upd_pc_i};

endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: directed scenarios plus random traffic
// against an arithmetic reference model.
module tb_bpu_gshare;
  import config_pkg::*;

  localparam cfg_t Cfg = EmptyCfg;
  localparam int VLEN = int'(Cfg.VLEN);
  localparam int FW   = int'(Cfg.FETCH_WIDTH);
  localparam int HL   = int'(Cfg.frontedn_hash_LEN);
  localparam int CW   = int'(Cfg.frontend_predict_LEN);
  localparam int NENT = 1 << HL;
  localparam int CINIT = (1 << (CW - 1)) - 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [VLEN-1:0] req_pc = '0;
  logic resp_valid;
  logic [FW-1:0] resp_taken;
  logic [HL-1:0] resp_ghr;
  logic spec_valid = 1'b0;
  logic spec_taken = 1'b0;
  logic upd_valid = 1'b0;
  logic [VLEN-1:0] upd_pc = '0;
  logic [HL-1:0] upd_ghr = '0;
  logic upd_taken = 1'b0;
  logic upd_mis = 1'b0;
  logic [HL-1:0] ghr_out;

  bpu_gshare #(.Cfg(Cfg)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_pc_i         (req_pc),
    .resp_valid_o     (resp_valid),
    .resp_taken_o     (resp_taken),
    .resp_ghr_o       (resp_ghr),
    .spec_valid_i     (spec_valid),
    .spec_taken_i     (spec_taken),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_ghr_i        (upd_ghr),
    .upd_taken_i      (upd_taken),
    .upd_mispredict_i (upd_mis),
    .ghr_o            (ghr_out)
  );

  always #5 clk = ~clk;

  int pht [NENT];
  int ghr;
  logic e_valid;
  logic [FW-1:0] e_taken;
  logic [HL-1:0] e_rghr;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) pht[i] = CINIT;
    ghr = 0;
    e_valid = 1'b0;
    e_taken = '0;
    e_rghr = '0;
  endtask

  function automatic logic [FW-1:0] predict(longint pc, int h);
    logic [FW-1:0] r;
    longint spc;
    int idx;
    r = '0;
    for (int i = 0; i < FW; i++) begin
      spc = (pc + 4 * i) % (longint'(1) << VLEN);
      idx = int'((spc / 4) % NENT) ^ h;
      r[i] = (pht[idx] >= (1 << (CW - 1)));
    end
    return r;
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 64'(resp_valid), 64'(e_valid));
    chk({tag, ".taken"}, 64'(resp_taken), 64'(e_taken));
    chk({tag, ".rghr"}, 64'(resp_ghr), 64'(e_rghr));
    chk({tag, ".ghr"}, 64'(ghr_out), 64'(ghr));
  endtask

  // Apply one cycle of stimulus, advance the model, check after the edge.
  task automatic drive(string tag, logic rq, logic [VLEN-1:0] pc,
                       logic sv, logic st, logic uv, bpu_upd_t u);
    int idx;
    @(negedge clk);
    req_valid = rq;
    req_pc = pc;
    spec_valid = sv;
    spec_taken = st;
    upd_valid = uv;
    upd_pc = u.pc;
    upd_ghr = u.ghr;
    upd_taken = u.taken;
    upd_mis = u.mispredict;
    e_valid = rq;
    if (rq) begin
      e_taken = predict(longint'(pc), ghr);
      e_rghr = HL'(ghr);
    end
    if (uv) begin
      idx = int'((longint'(u.pc) / 4) % NENT) ^ int'(u.ghr);
      if (u.taken) pht[idx] = (pht[idx] < CMAX) ? pht[idx] + 1 : CMAX;
      else pht[idx] = (pht[idx] > 0) ? pht[idx] - 1 : 0;
    end
    if (uv && u.mispredict) ghr = (int'(u.ghr) * 2 + int'(u.taken)) % NENT;
    else if (sv) ghr = (ghr * 2 + int'(st)) % NENT;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic bpu_upd_t mk(logic [VLEN-1:0] pc, logic [HL-1:0] h,
                                  logic t, logic m);
    bpu_upd_t u;
    u.pc = pc;
    u.ghr = h;
    u.taken = t;
    u.mispredict = m;
    return u;
  endfunction

  localparam logic [VLEN-1:0] PC0 = 32'h8000_0000;

  initial begin
    bpu_upd_t none;
    bpu_upd_t tr;
    none = mk('0, '0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    drive("req0", 1'b1, PC0, 1'b0, 1'b0, 1'b0, none);
    tr = mk(PC0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive("train", 1'b0, '0, 1'b0, 1'b0, 1'b1, tr);
    chk("cnt0_sat", 64'(pht[0]), 64'(CMAX));
    drive("req_trained", 1'b1, PC0, 1'b0, 1'b0, 1'b0, none);
    chk("trained_bits", 64'(resp_taken), 64'h1);

    drive("spec1", 1'b0, '0, 1'b1, 1'b1, 1'b0, none);
    drive("spec0", 1'b0, '0, 1'b1, 1'b0, 1'b0, none);
    drive("spec1b", 1'b0, '0, 1'b1, 1'b1, 1'b0, none);
    chk("ghr_0101", 64'(ghr_out), 64'h5);
    drive("misp", 1'b0, '0, 1'b0, 1'b0, 1'b1, mk(PC0, 4'b0101, 1'b1, 1'b1));
    chk("ghr_1011", 64'(ghr_out), 64'hB);
    drive("misp_vs_spec", 1'b0, '0, 1'b1, 1'b0, 1'b1,
          mk(PC0, 4'b0011, 1'b0, 1'b1));
    chk("ghr_0110", 64'(ghr_out), 64'h6);

    drive("rbw_same", 1'b1, PC0, 1'b0, 1'b0, 1'b1,
          mk(PC0, 4'b0110, 1'b1, 1'b0));
    chk("rbw_old_bit0", 64'(resp_taken[0]), 64'h0);
    drive("rbw_next", 1'b1, PC0, 1'b0, 1'b0, 1'b0, none);
    chk("rbw_new_bit0", 64'(resp_taken[0]), 64'h1);

    drive("wrap", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, none);
    drive("hold", 1'b0, '0, 1'b0, 1'b0, 1'b0, none);

    @(negedge clk);
    req_valid = 1'b1;
    req_pc = PC0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    drive("post_reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, none);
    for (int i = 0; i < NENT / FW; i++)
      drive("cinit_scan", 1'b1, VLEN'(i * FW * 4), 1'b0, 1'b0, 1'b0, none);

    for (int i = 0; i < 400; i++) begin
      logic [VLEN-1:0] pc;
      bpu_upd_t u;
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | VLEN'($urandom_range(0, 3) * 4))
                                       : PC0 + VLEN'($urandom_range(0, 15) * 4);
      u = mk(PC0 + VLEN'($urandom_range(0, 15) * 4), HL'($urandom),
             1'($urandom), ($urandom_range(0, 5) == 0));
      drive("rand", 1'($urandom), pc, 1'($urandom), 1'($urandom),
            1'($urandom), u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
